// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: IEEE 1149.1 state encoding and instruction opcodes.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SHIFT_DR = 4'h2,
    EXIT1_DR = 4'h1,
    PAUSE_DR = 4'h3,
    EXIT2_DR = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SHIFT_IR = 4'hA,
    EXIT1_IR = 4'h9,
    PAUSE_IR = 4'hB,
    EXIT2_IR = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  localparam logic [3:0] OP_IDCODE  = 4'b0001;
  localparam logic [3:0] OP_USER    = 4'b1000;
  localparam logic [3:0] OP_BYPASS  = 4'b1111;
  localparam int         USER_WIDTH = 8;

  function automatic logic is_shift(input tap_state_t s);
    return (s == SHIFT_DR) || (s == SHIFT_IR);
  endfunction

endpackage

// File: rtl/jtag_sync.sv
// Brings tck/tms/tdi into the clk domain and turns tck into single-cycle rise/fall pulses.
module jtag_sync
  import jtag_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tms_s,
  output logic tdi_s,
  output logic tck_rise,
  output logic tck_fall
);

  logic [1:0] tck_ff;
  logic [1:0] tms_ff;
  logic [1:0] tdi_ff;
  logic       tck_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_ff <= 2'b00;
      tms_ff <= 2'b00;
      tdi_ff <= 2'b00;
      tck_d  <= 1'b0;
    end else begin
      tck_ff <= {tck_ff[0], tck};
      tms_ff <= {tms_ff[0], tms};
      tdi_ff <= {tdi_ff[0], tdi};
      tck_d  <= tck_ff[1];
    end
  end

  // Edges come from two registered samples, so rise and fall can never coincide.
  assign tck_rise = tck_ff[1] & ~tck_d;
  assign tck_fall = ~tck_ff[1] & tck_d;
  assign tms_s    = tms_ff[1];
  assign tdi_s    = tdi_ff[1];

endmodule

// File: rtl/jtag_tap.sv
// Oversampled IEEE 1149.1 TAP controller with IDCODE and BYPASS data registers.
// Define JTAG_TAP_USERREG_EN to add an 8-bit user data register on opcode 4'b1000.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE   = 32'h4A7E_C001,
  parameter int          IR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_oe,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_out
`ifdef JTAG_TAP_USERREG_EN
  ,
  output logic [USER_WIDTH-1:0] user_data,
  output logic                  user_update
`endif
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_TAP_USERREG_EN
  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(OP_USER);
`endif

  logic tms_s, tdi_s, tck_rise, tck_fall;

  tap_state_t          state, next_state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         idcode_shift;
  logic                bypass_reg;
  logic                sel_idcode;
  logic                dr_lsb;
`ifdef JTAG_TAP_USERREG_EN
  logic [USER_WIDTH-1:0] user_shift;
  logic                  sel_user;
`endif

  jtag_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst)           state <= TLR;
    else if (tck_rise) state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = tms_s ? TLR      : RTI;
      RTI:      next_state = tms_s ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = tms_s ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = tms_s ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms_s ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = tms_s ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = tms_s ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  always_comb begin
    tap_state = state;
    tdo_oe    = is_shift(state);
  end

  // Anything that is neither IDCODE nor an enabled user opcode falls back to BYPASS.
  always_comb begin
    sel_idcode = (ir_out == IR_IDCODE);
`ifdef JTAG_TAP_USERREG_EN
    sel_user   = (ir_out == IR_USER);
    dr_lsb     = sel_idcode ? idcode_shift[0] : (sel_user ? user_shift[0] : bypass_reg);
`else
    dr_lsb     = sel_idcode ? idcode_shift[0] : bypass_reg;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_shift     <= '0;
      ir_out       <= IR_IDCODE;
      idcode_shift <= '0;
      bypass_reg   <= 1'b0;
      tdo          <= 1'b0;
`ifdef JTAG_TAP_USERREG_EN
      user_shift   <= '0;
      user_data    <= '0;
      user_update  <= 1'b0;
`endif
    end else begin
`ifdef JTAG_TAP_USERREG_EN
      user_update <= 1'b0;
`endif
      if (tck_rise) begin
        case (state)
          CAP_IR:   ir_shift <= IR_CAPTURE;
          SHIFT_IR: ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
          UPD_IR:   ir_out   <= ir_shift;
          CAP_DR: begin
            bypass_reg <= 1'b0;
            if (sel_idcode) idcode_shift <= IDCODE;
`ifdef JTAG_TAP_USERREG_EN
            if (sel_user)   user_shift   <= user_data;
`endif
          end
          SHIFT_DR: begin
            if (sel_idcode) idcode_shift <= {tdi_s, idcode_shift[31:1]};
`ifdef JTAG_TAP_USERREG_EN
            else if (sel_user) user_shift <= {tdi_s, user_shift[USER_WIDTH-1:1]};
`endif
            else bypass_reg <= tdi_s;
          end
`ifdef JTAG_TAP_USERREG_EN
          UPD_DR: begin
            if (sel_user) begin
              user_data   <= user_shift;
              user_update <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
        if (next_state == TLR) ir_out <= IR_IDCODE;
      end else if (tck_fall) begin
        if (state == SHIFT_IR)      tdo <= ir_shift[0];
        else if (state == SHIFT_DR) tdo <= dr_lsb;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap; exercises the user register when JTAG_TAP_USERREG_EN is defined.
module tb_jtag_tap;

  localparam int          IRW = 4;
  localparam logic [31:0] IDC = 32'h4A7E_C001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tck = 1'b0;
  logic tms = 1'b0;
  logic tdi = 1'b0;
  logic           tdo, tdo_oe;
  logic [3:0]     tap_state;
  logic [IRW-1:0] ir_out;
`ifdef JTAG_TAP_USERREG_EN
  logic [7:0] user_data;
  logic       user_update;
  int         pulse_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];

  always #5 clk = ~clk;

  jtag_tap dut (
    .clk       (clk),
    .rst       (rst),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tdo_oe    (tdo_oe),
    .tap_state (tap_state),
    .ir_out    (ir_out)
`ifdef JTAG_TAP_USERREG_EN
    ,
    .user_data   (user_data),
    .user_update (user_update)
`endif
  );

`ifdef JTAG_TAP_USERREG_EN
  always @(negedge clk) if (user_update) pulse_cnt++;
`endif

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // IEEE 1149.1 state graph written as a lookup table: next state for tms=0 / tms=1.
  task automatic init_model;
    nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
    nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
    nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
    nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
    nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
    nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
    nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
    nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
    nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
    nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
    nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
    nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
    nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
    nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
    nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
    nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;
  endtask

  // Expected serial DR output: captured value shifted out LSB first, followed by tdi bits.
  function automatic logic [31:0] model_dr(input logic [IRW-1:0] op, input int n,
                                           input logic [31:0] d, input logic [7:0] ud);
    logic [63:0] s;
    logic [31:0] mask;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    if (op == 4'b0001) s = {32'h0, IDC};
`ifdef JTAG_TAP_USERREG_EN
    else if (op == 4'b1000) s = {24'h0, d, ud};
`endif
    else s = {31'h0, d, 1'b0};
    return s[31:0] & mask;
  endfunction

  task automatic tick(input logic m, input logic d, output logic o);
    tms = m;
    tdi = d;
    repeat (3) @(negedge clk);
    tck = 1'b1;
    repeat (4) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
    o = tdo;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic shift_ir(input logic [IRW-1:0] v, output logic [IRW-1:0] cap);
    logic o;
    cap = '0;
    tick(1'b1, 1'b0, o);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    cap[0] = o;
    for (int i = 0; i < IRW; i++) begin
      tick(i == IRW - 1, v[i], o);
      if (i < IRW - 1) cap[i+1] = o;
    end
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] d, output logic [31:0] q);
    logic o;
    q = '0;
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    q[0] = o;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, d[i], o);
      if (i < n - 1) q[i+1] = o;
    end
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (tap_state !== 4'hF) begin errors++; $display("[TB] FAIL reset_state got %h expected f", tap_state); end
    checks++; if (ir_out !== 4'b0001) begin errors++; $display("[TB] FAIL reset_ir got %b expected 0001", ir_out); end
    checks++; if (tdo_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe got %b expected 0", tdo_oe); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("[TB] FAIL reset_tdo got %b expected 0", tdo); end
`ifdef JTAG_TAP_USERREG_EN
    checks++; if (user_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_user got %h expected 00", user_data); end
`endif
  endtask

  task automatic test_idcode;
    logic o;
    logic [31:0] q;
    do_reset();
    tick(1'b0, 1'b0, o);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    q = '0;
    q[0] = o;
    checks++; if (tap_state !== 4'h2) begin errors++; $display("[TB] FAIL idcode_shiftdr got %h expected 2", tap_state); end
    checks++; if (tdo_oe !== 1'b1) begin errors++; $display("[TB] FAIL idcode_oe got %b expected 1", tdo_oe); end
    for (int i = 0; i < 32; i++) begin
      tick(i == 31, 1'($urandom_range(0, 1)), o);
      if (i < 31) q[i+1] = o;
    end
    checks++; if (q !== IDC) begin errors++; $display("[TB] FAIL idcode_data got %h expected %h", q, IDC); end
    checks++; if (tap_state !== 4'h1) begin errors++; $display("[TB] FAIL idcode_exit got %h expected 1", tap_state); end
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    checks++; if (tap_state !== 4'hC) begin errors++; $display("[TB] FAIL idcode_rti got %h expected c", tap_state); end
  endtask

  task automatic test_bypass;
    logic [IRW-1:0] cap;
    logic [31:0] q, d, exp;
    shift_ir(4'b1111, cap);
    checks++; if (cap !== 4'b0001) begin errors++; $display("[TB] FAIL bypass_capir got %b expected 0001", cap); end
    checks++; if (ir_out !== 4'b1111) begin errors++; $display("[TB] FAIL bypass_ir got %b expected 1111", ir_out); end
    shift_dr(4, 32'b1101, q);
    checks++; if (q[3:0] !== 4'b1010) begin errors++; $display("[TB] FAIL bypass_1011 got %b expected 1010", q[3:0]); end
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      exp = model_dr(4'b1111, 16, d, 8'h00);
      shift_dr(16, d, q);
      checks++; if (q !== exp) begin errors++; $display("[TB] FAIL bypass_rand got %h expected %h", q, exp); end
    end
  endtask

  task automatic test_undefined;
    logic [IRW-1:0] cap, op;
    logic [31:0] q, d, exp;
    for (int k = 0; k < 5; k++) begin
`ifdef JTAG_TAP_USERREG_EN
      do op = 4'($urandom_range(0, 15)); while (op == 4'b0001 || op == 4'b1111 || op == 4'b1000);
`else
      if (k == 0) op = 4'b1000;
      else do op = 4'($urandom_range(0, 15)); while (op == 4'b0001 || op == 4'b1111);
`endif
      shift_ir(op, cap);
      checks++; if (cap !== 4'b0001) begin errors++; $display("[TB] FAIL undef_capir got %b expected 0001", cap); end
      checks++; if (ir_out !== op) begin errors++; $display("[TB] FAIL undef_ir got %b expected %b", ir_out, op); end
      d = $urandom;
      exp = model_dr(op, 12, d, 8'h00);
      shift_dr(12, d, q);
      checks++; if (q !== exp) begin errors++; $display("[TB] FAIL undef_dr op %b got %h expected %h", op, q, exp); end
    end
  endtask

  task automatic test_tlr_walk;
    logic [IRW-1:0] cap;
    logic [3:0] m_state;
    logic o, b;
    int len;
    for (int k = 0; k < 6; k++) begin
      shift_ir(4'($urandom_range(0, 15)), cap);
      m_state = 4'hC;
      len = $urandom_range(3, 20);
      for (int s = 0; s < len; s++) begin
        b = 1'($urandom_range(0, 1));
        tick(b, 1'($urandom_range(0, 1)), o);
        m_state = b ? nxt1[m_state] : nxt0[m_state];
        checks++; if (tap_state !== m_state) begin errors++; $display("[TB] FAIL walk_state got %h expected %h", tap_state, m_state); end
      end
      for (int s = 0; s < 5; s++) tick(1'b1, 1'b0, o);
      checks++; if (tap_state !== 4'hF) begin errors++; $display("[TB] FAIL walk_tlr got %h expected f", tap_state); end
      checks++; if (ir_out !== 4'b0001) begin errors++; $display("[TB] FAIL walk_ir got %b expected 0001", ir_out); end
      tick(1'b0, 1'b0, o);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic o;
    logic [31:0] q;
    do_reset();
    tick(1'b0, 1'b0, o);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom_range(0, 1)), o);
    checks++; if (tdo_oe !== 1'b1) begin errors++; $display("[TB] FAIL midrst_oe_pre got %b expected 1", tdo_oe); end
    do_reset();
    checks++; if (tap_state !== 4'hF) begin errors++; $display("[TB] FAIL midrst_state got %h expected f", tap_state); end
    checks++; if (ir_out !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_ir got %b expected 0001", ir_out); end
    checks++; if (tdo_oe !== 1'b0) begin errors++; $display("[TB] FAIL midrst_oe got %b expected 0", tdo_oe); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tdo got %b expected 0", tdo); end
    tick(1'b0, 1'b0, o);
    shift_dr(32, $urandom, q);
    checks++; if (q !== IDC) begin errors++; $display("[TB] FAIL midrst_idcode got %h expected %h", q, IDC); end
  endtask

`ifdef JTAG_TAP_USERREG_EN
  task automatic test_user;
    logic [IRW-1:0] cap;
    logic [31:0] q, exp, d;
    logic [7:0] m_user;
    logic o;
    do_reset();
    tick(1'b0, 1'b0, o);
    shift_ir(4'b1000, cap);
    m_user = 8'h00;
    pulse_cnt = 0;
    exp = model_dr(4'b1000, 8, 32'hA5, m_user);
    shift_dr(8, 32'hA5, q);
    m_user = 8'hA5;
    checks++; if (q !== exp) begin errors++; $display("[TB] FAIL user_first got %h expected %h", q, exp); end
    checks++; if (user_data !== m_user) begin errors++; $display("[TB] FAIL user_data got %h expected %h", user_data, m_user); end
    checks++; if (pulse_cnt !== 1) begin errors++; $display("[TB] FAIL user_pulse got %0d expected 1", pulse_cnt); end
    for (int k = 0; k < 3; k++) begin
      d = {24'h0, 8'($urandom)};
      exp = model_dr(4'b1000, 8, d, m_user);
      pulse_cnt = 0;
      shift_dr(8, d, q);
      m_user = d[7:0];
      checks++; if (q !== exp) begin errors++; $display("[TB] FAIL user_readback got %h expected %h", q, exp); end
      checks++; if (user_data !== m_user) begin errors++; $display("[TB] FAIL user_rand got %h expected %h", user_data, m_user); end
      checks++; if (pulse_cnt !== 1) begin errors++; $display("[TB] FAIL user_pulse_rand got %0d expected 1", pulse_cnt); end
    end
    checks++; if (user_update !== 1'b0) begin errors++; $display("[TB] FAIL user_update_idle got %b expected 0", user_update); end
  endtask
`endif

  initial begin
    init_model();
    test_reset();
    test_idcode();
    test_bypass();
    test_undefined();
    test_tlr_walk();
    test_reset_mid_shift();
`ifdef JTAG_TAP_USERREG_EN
    test_user();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
